// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - fetch sequencer bus: imem req/gnt/rvalid, decode valid/ack, branch redirect
interface pc_fetch_ctrl_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ack;
    logic               br_valid;
    logic [PC_W-1:0]    br_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ack, br_valid, br_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ack, br_valid, br_target
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC owner and fetch sequencer between imem and decode
// Optional WAIT-state timeout with sticky fetch_err: define FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    pc_fetch_ctrl_if.master      bus,
    output logic [PC_W-1:0]      pc,
    output logic                 fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc_q, pc_nxt;
    logic               valid_q, valid_nxt;
    logic [INSTR_W-1:0] instr_q, instr_nxt;
    logic [PC_W-1:0]    ipc_q, ipc_nxt;
    logic               pend_q, pend_nxt;
    logic [PC_W-1:0]    tgt_q, tgt_nxt;
    logic               timeout_hit;
    logic               err_block;
    logic               redirect_now;
    logic [PC_W-1:0]    redirect_pc;
    state_t             resume_state;

    assign bus.imem_req    = (state == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign pc              = pc_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tcnt_q;
    logic             err_q;

    assign timeout_hit = (state == WAIT) && !bus.imem_rvalid
                         && ((tcnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));
    assign err_block   = err_q;
    assign fetch_err   = err_q;

    // Counter is held at zero outside WAIT, so it starts fresh on every WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != WAIT)
                tcnt_q <= '0;
            else if (!bus.imem_rvalid)
                tcnt_q <= tcnt_q + CNT_W'(1);
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign err_block      = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    // A redirect arriving this cycle takes priority over one already latched.
    assign redirect_now = bus.br_valid || pend_q;
    assign redirect_pc  = bus.br_valid ? bus.br_target : tgt_q;
    assign resume_state = run ? FETCH : IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            valid_q <= valid_nxt;
            instr_q <= instr_nxt;
            ipc_q   <= ipc_nxt;
            pend_q  <= pend_nxt;
            tgt_q   <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        valid_nxt = valid_q;
        instr_nxt = instr_q;
        ipc_nxt   = ipc_q;
        pend_nxt  = pend_q;
        tgt_nxt   = tgt_q;
        case (state)
            IDLE: begin
                if (bus.br_valid)
                    pc_nxt = bus.br_target;
                if (run && !err_block)
                    state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.br_valid)
                    pc_nxt = bus.br_target;
                // A grant coinciding with a redirect is still accepted; its data gets dropped.
                if (bus.imem_gnt) begin
                    state_nxt = WAIT;
                    if (bus.br_valid) begin
                        pend_nxt = 1'b1;
                        tgt_nxt  = bus.br_target;
                    end
                end
            end
            WAIT: begin
                if (bus.br_valid) begin
                    pend_nxt = 1'b1;
                    tgt_nxt  = bus.br_target;
                end
                if (bus.imem_rvalid) begin
                    if (redirect_now) begin
                        pc_nxt    = redirect_pc;
                        pend_nxt  = 1'b0;
                        state_nxt = resume_state;
                    end else begin
                        instr_nxt = bus.imem_rdata;
                        ipc_nxt   = pc_q;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_q + PC_W'(1);
                        state_nxt = HOLD;
                    end
                end else if (timeout_hit) begin
                    if (redirect_now)
                        pc_nxt = redirect_pc;
                    pend_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (bus.br_valid) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = bus.br_target;
                    state_nxt = resume_state;
                end else if (bus.instr_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = resume_state;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl with behavioural imem and decode
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic [7:0] pc;
    logic fetch_err;

    pc_fetch_ctrl_if #(.PC_W(8), .INSTR_W(32)) bus ();

    pc_fetch_ctrl #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .pc        (pc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    logic        shown, pend_mem, br_in_flight, rv_en, ack_en, data_ovr_en, bad_en, br_req;
    logic [7:0]  mem_addr, bad_addr, br_tgt, show_pc;
    logic [31:0] data_ovr;
    int          rv_cnt, rv_delay, n_shown;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs just after the edge, then drive memory/decode/redirect inputs.
    task automatic tick();
        logic        br_now;
        logic [31:0] d;
        exp_t        e;
        @(posedge clk);
        #1;
        if (!bus.instr_valid) begin
            shown = 1'b0;
        end else if (!shown) begin
            shown   = 1'b1;
            n_shown++;
            show_pc = pc;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("instr_pc", bus.instr_pc, e.pc);
                chk("instr", bus.instr, e.data);
            end
        end
        if (bad_en && bus.imem_req)
            chk("no_old_req", bus.imem_addr == bad_addr, 0);

        br_now = br_req;
        br_req = 1'b0;
        bus.br_valid    = br_now;
        bus.br_target   = br_tgt;
        bus.imem_rvalid = 1'b0;
        if (pend_mem && rv_en) begin
            if (rv_cnt == 0) begin
                d = data_ovr_en ? data_ovr : (32'h1000 + {24'h0, mem_addr});
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = d;
                if (!(br_in_flight || br_now))
                    sb.push_back({mem_addr, d});
                pend_mem     = 1'b0;
                br_in_flight = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        bus.imem_gnt = bus.imem_req && !pend_mem;
        if (bus.imem_gnt) begin
            pend_mem = 1'b1;
            rv_cnt   = rv_delay;
            mem_addr = bus.imem_addr;
        end
        if (br_now && pend_mem)
            br_in_flight = 1'b1;
        bus.instr_ack = ack_en && bus.instr_valid;
    endtask

    task automatic wait_shown(input int target);
        int n = 0;
        while (n_shown < target && n < 60) begin
            tick();
            n++;
        end
        if (n_shown < target)
            chk("wait_shown_bound", n_shown, target);
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.imem_req && n < 20);
        if (!bus.imem_req)
            chk("wait_req_bound", bus.imem_req, 1);
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.imem_gnt && n < 20);
        if (!bus.imem_gnt)
            chk("wait_gnt_bound", bus.imem_gnt, 1);
    endtask

    task automatic redirect_idle(input logic [7:0] tgt);
        br_req = 1'b1;
        br_tgt = tgt;
        tick();
        tick();
        chk("redirect_pc", pc, tgt);
    endtask

    task automatic drain();
        run    = 1'b0;
        ack_en = 1'b1;
        repeat (12) tick();
        chk("sb_drained", sb.size(), 0);
        chk("idle_no_req", bus.imem_req, 0);
        bad_en      = 1'b0;
        data_ovr_en = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        shown = 1'b0; pend_mem = 1'b0; br_in_flight = 1'b0; br_req = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.instr_ack = 1'b0; bus.br_valid = 1'b0; bus.br_target = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; run = 1'b0;
        rv_en = 1'b1; ack_en = 1'b1; data_ovr_en = 1'b0; bad_en = 1'b0;
        rv_delay = 0; rv_cnt = 0; n_shown = 0; br_tgt = '0; bad_addr = '0;
        mem_addr = '0; data_ovr = '0; show_pc = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_fetch_err", fetch_err, 0);
        rst = 1'b0;

        // Free run from reset: latency 3, then one instruction per 3 cycles.
        run = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.instr_valid && n < 20);
        chk("first_latency", n, 3);
        while (n_shown < 3 && n < 40) begin
            tick();
            n++;
        end
        chk("three_instr_cycles", n, 9);
        drain();
        chk("pc_after_run", pc, 8'h03);

        // PC wrap through 0xFF.
        redirect_idle(8'hFE);
        run = 1'b1;
        wait_shown(n_shown + 2);
        chk("wrap_pc_after_ff", show_pc, 8'h00);
        wait_shown(n_shown + 1);
        chk("wrap_pc_after_00", show_pc, 8'h01);
        drain();

        // Decode stall: held instruction stays put, no new request.
        redirect_idle(8'h04);
        ack_en = 1'b0; data_ovr_en = 1'b1; data_ovr = 32'hDEADBEEF;
        run = 1'b1;
        wait_shown(n_shown + 1);
        data_ovr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid", bus.instr_valid, 1);
            chk("stall_instr", bus.instr, 32'hDEADBEEF);
            chk("stall_instr_pc", bus.instr_pc, 8'h04);
            chk("stall_no_req", bus.imem_req, 0);
            chk("stall_pc", pc, 8'h05);
        end
        ack_en = 1'b1;
        tick();
        tick();
        chk("after_ack_req", bus.imem_req, 1);
        chk("after_ack_addr", bus.imem_addr, 8'h05);
        drain();

        // Redirect while WAIT, rvalid two cycles later: 0xBAD must be dropped.
        redirect_idle(8'h10);
        rv_delay = 2; data_ovr_en = 1'b1; data_ovr = 32'h0000_0BAD;
        bad_en = 1'b1; bad_addr = 8'h11;
        run = 1'b1;
        wait_gnt();
        br_req = 1'b1; br_tgt = 8'h40;
        wait_req();
        chk("wait_br_addr", bus.imem_addr, 8'h40);
        data_ovr_en = 1'b0; rv_delay = 0;
        wait_shown(n_shown + 1);
        drain();

        // Redirect coincident with rvalid.
        redirect_idle(8'h20);
        rv_delay = 2; data_ovr_en = 1'b1; data_ovr = 32'h0000_0BAD;
        bad_en = 1'b1; bad_addr = 8'h21;
        run = 1'b1;
        wait_gnt();
        tick();
        tick();
        br_req = 1'b1; br_tgt = 8'h40;
        wait_req();
        chk("coinc_br_addr", bus.imem_addr, 8'h40);
        data_ovr_en = 1'b0; rv_delay = 0;
        wait_shown(n_shown + 1);
        drain();

        // Redirect in HOLD with simultaneous ack.
        redirect_idle(8'h30);
        ack_en = 1'b0;
        run = 1'b1;
        wait_shown(n_shown + 1);
        ack_en = 1'b1; bad_en = 1'b1; bad_addr = 8'h31;
        br_req = 1'b1; br_tgt = 8'h80;
        tick();
        tick();
        chk("hold_br_valid", bus.instr_valid, 0);
        chk("hold_br_req", bus.imem_req, 1);
        chk("hold_br_addr", bus.imem_addr, 8'h80);
        wait_shown(n_shown + 1);
        drain();

        // Memory grants but never returns data.
        rv_en = 1'b0;
        redirect_idle(8'h50);
        run = 1'b1;
        wait_gnt();
        for (int k = 1; k <= 26; k++) begin
            tick();
`ifdef FETCH_TIMEOUT_EN
            if (k == 15) chk("err_before_timeout", fetch_err, 0);
            if (k == 16) chk("err_at_timeout", fetch_err, 1);
`else
            if (k == 16) chk("err_disabled", fetch_err, 0);
`endif
            if (k >= 16) chk("no_req_after_stall", bus.imem_req, 0);
        end
        chk("stall_pc_kept", pc, 8'h50);

        // Asynchronous reset mid-operation, then a fresh fetch from RESET_PC.
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.instr_valid, 0);
        chk("mid_rst_req", bus.imem_req, 0);
        chk("mid_rst_pc", pc, 8'h00);
        chk("mid_rst_err", fetch_err, 0);
        run = 1'b0; rv_en = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        wait_shown(n_shown + 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
